// File: rtl/mem_stage_ctrl_pkg.sv
// Shared definitions for the M-stage memory access controller.
package mem_stage_ctrl_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;

    // Default wait budget in cycles and the load value returned on an error.
    localparam int unsigned        TIMEOUT_DEF  = 16;
    localparam logic [DATA_W-1:0]  ERR_DATA_DEF = 32'h0000_0000;

    // Word alignment: any of these address bits set means a misaligned access.
    localparam logic [ADDR_W-1:0]  ALIGN_MASK   = 32'h0000_0003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mem_state_e;

endpackage

// File: rtl/mem_stage_ctrl_wait_timer.sv
// Wait-cycle counter for an outstanding memory request; flags the last allowed cycle.
module mem_wait_timer
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_c_o
);

    localparam int unsigned       CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0]  LAST  = CNT_W'(TIMEOUT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and hold at the last value.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && (cnt_q != LAST)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c_o = enable_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_stage_ctrl.sv
// M-stage memory access controller: stalls the pipeline while a single
// load/store is serviced by a handshaked memory, with alignment and timeout checks.
module mem_stage_ctrl
    import mem_stage_ctrl_pkg::*;
#(
    parameter int unsigned       TIMEOUT  = TIMEOUT_DEF,
    parameter logic [DATA_W-1:0] ERR_DATA = ERR_DATA_DEF
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              MemWriteM,
    input  logic              MemtoRegM,
    input  logic [ADDR_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] WriteDataM,
    input  logic              MemReady,
    input  logic [DATA_W-1:0] MemRData,
    output logic              MemReq,
    output logic              MemWE,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWData,
    output logic              StallM,
    output logic [DATA_W-1:0] ReadDataM,
    output logic              ReadValidM,
    output logic              AlignErr,
    output logic              TimeoutErr
);

    mem_state_e        state_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] read_data_q;
    logic              read_valid_q;
    logic              align_err_q;
    logic              timeout_err_q;

    logic access_c;
    logic is_load_c;
    logic aligned_c;
    logic busy_c;
    logic expired_c;

    assign access_c  = MemWriteM | MemtoRegM;
    assign is_load_c = MemtoRegM & ~MemWriteM;
    assign aligned_c = ((ALUOutM & ALIGN_MASK) == '0);
    assign busy_c    = (state_q == ST_BUSY);

    mem_wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk         (CLK),
        .rst_n       (Reset),
        .clear_i     (~busy_c | MemReady),
        .enable_i    (busy_c),
        .expired_c_o (expired_c)
    );

    // Access FSM with registered request, result and sticky error outputs.
    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            read_data_q   <= '0;
            read_valid_q  <= 1'b0;
            align_err_q   <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            read_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (access_c) begin
                        if (aligned_c) begin
                            state_q     <= ST_BUSY;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= MemWriteM;
                            mem_addr_q  <= ALUOutM;
                            mem_wdata_q <= WriteDataM;
                        end else begin
                            // Misaligned: no request; a load still completes with ERR_DATA.
                            state_q      <= ST_DONE;
                            align_err_q  <= 1'b1;
                            read_valid_q <= is_load_c;
                            if (is_load_c) begin
                                read_data_q <= ERR_DATA;
                            end
                        end
                    end
                end
                ST_BUSY: begin
                    // MemReady outranks the timeout on the last allowed cycle.
                    if (MemReady) begin
                        state_q      <= ST_DONE;
                        mem_req_q    <= 1'b0;
                        read_valid_q <= ~mem_we_q;
                        if (!mem_we_q) begin
                            read_data_q <= MemRData;
                        end
                    end else if (expired_c) begin
                        state_q       <= ST_DONE;
                        mem_req_q     <= 1'b0;
                        timeout_err_q <= 1'b1;
                        read_valid_q  <= ~mem_we_q;
                        if (!mem_we_q) begin
                            read_data_q <= ERR_DATA;
                        end
                    end
                end
                ST_DONE: begin
                    // Pipeline advances this cycle, so the serviced access is not re-seen.
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    // Stall is combinational so the access is held from its first M-stage cycle.
    assign StallM = Reset & (((state_q == ST_IDLE) & access_c) | busy_c);

    assign MemReq     = mem_req_q;
    assign MemWE      = mem_we_q;
    assign MemAddr    = mem_addr_q;
    assign MemWData   = mem_wdata_q;
    assign ReadDataM  = read_data_q;
    assign ReadValidM = read_valid_q;
    assign AlignErr   = align_err_q;
    assign TimeoutErr = timeout_err_q;

endmodule
